// File: rtl/mov_sequencer.sv
// mov_sequencer: turns a 64-bit constant into an ordered MOVZ/MOVK step
// sequence, one 16-bit halfword per step, lowest halfword first.
// One constant is in flight at a time; both sides use valid/ready.
module mov_sequencer #(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_imm,
  output logic [1:0]  out_shift,
  output logic        out_keep,
  output logic        out_last,
  output logic [2:0]  step_count
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [63:0] value_reg;
  logic [3:0]  mask_reg;
  logic [2:0]  count_reg;

  logic [3:0]  raw_mask;
  logic [3:0]  cap_mask;
  logic [1:0]  idx;
  logic        last_step;
  logic        accept_in;
  logic        accept_out;

  // One mask bit per halfword: set when that halfword needs a step.
  for (genvar gi = 0; gi < 4; gi++) begin : g_mask
    assign raw_mask[gi] = SKIP_ZERO ? (|in_value[16*gi +: 16]) : 1'b1;
  end

  // A zero constant still needs a single MOVZ #0 to clear the register.
  assign cap_mask = (raw_mask == 4'b0000) ? 4'b0001 : raw_mask;

  // Current step is the lowest pending halfword.
  always_comb begin
    idx = 2'd0;
    if (mask_reg[0])      idx = 2'd0;
    else if (mask_reg[1]) idx = 2'd1;
    else if (mask_reg[2]) idx = 2'd2;
    else if (mask_reg[3]) idx = 2'd3;
  end

  assign last_step  = (mask_reg != 4'b0000) && ((mask_reg & (mask_reg - 4'd1)) == 4'b0000);
  assign accept_in  = in_valid && in_ready;
  assign accept_out = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && last_step) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the constant, then retire one mask bit per accepted step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_reg <= 64'd0;
      mask_reg  <= 4'd0;
      count_reg <= 3'd0;
    end else if (accept_in) begin
      value_reg <= in_value;
      mask_reg  <= cap_mask;
      count_reg <= 3'd0;
    end else if (accept_out) begin
      mask_reg  <= mask_reg & ~(4'b0001 << idx);
      count_reg <= count_reg + 3'd1;
    end
  end

  // Step fields are derived from held registers, so they stay stable
  // under backpressure and read as zero while idle.
  assign out_imm    = out_valid ? value_reg[{idx, 4'b0000} +: 16] : 16'd0;
  assign out_shift  = out_valid ? idx : 2'd0;
  assign out_keep   = out_valid && (count_reg != 3'd0);
  assign out_last   = out_valid && last_step;
  assign step_count = count_reg;

endmodule

// File: tb/tb_mov_sequencer.sv
// tb_mov_sequencer: scoreboard bench for mov_sequencer. Instance 0 has
// SKIP_ZERO=0, instance 1 has SKIP_ZERO=1; only one is active at a time.
module tb_mov_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid   [2];
  logic        in_ready   [2];
  logic [63:0] in_value   [2];
  logic        out_valid  [2];
  logic        out_ready  [2];
  logic [15:0] out_imm    [2];
  logic [1:0]  out_shift  [2];
  logic        out_keep   [2];
  logic        out_last   [2];
  logic [2:0]  step_count [2];

  always #5 clk = ~clk;

  mov_sequencer #(.SKIP_ZERO(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_value(in_value[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_imm(out_imm[0]),
    .out_shift(out_shift[0]), .out_keep(out_keep[0]), .out_last(out_last[0]),
    .step_count(step_count[0])
  );

  mov_sequencer #(.SKIP_ZERO(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_value(in_value[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_imm(out_imm[1]),
    .out_shift(out_shift[1]), .out_keep(out_keep[1]), .out_last(out_last[1]),
    .step_count(step_count[1])
  );

  typedef struct {
    int          d;
    logic [15:0] imm;
    logic [1:0]  shift;
    logic        keep;
    logic        last;
    logic [63:0] value;
  } step_t;

  step_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input logic [15:0] imm, input logic [1:0] sh,
                      input logic k, input logic l, input logic [63:0] v);
    step_t e;
    e.d = d; e.imm = imm; e.shift = sh; e.keep = k; e.last = l; e.value = v;
    exp_q.push_back(e);
  endtask

  // Monitor: pops an expectation per accepted step, checks stall stability,
  // and replays steps into a register to confirm the constant is rebuilt.
  logic        stall_seen [2];
  logic [20:0] stall_out  [2];
  logic [63:0] rep        [2];
  step_t       mon_e;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        stall_seen[d] = 1'b0;
      end else begin
        if (stall_seen[d]) begin
          chk("stall_valid", 64'(out_valid[d]), 64'd1);
          if (out_valid[d])
            chk("stall_hold", 64'({out_imm[d], out_shift[d], out_keep[d], out_last[d]}),
                64'(stall_out[d]));
        end
        if (out_valid[d] && out_ready[d]) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_step: got imm=%h shift=%0d on dut%0d, want none",
                     out_imm[d], out_shift[d], d);
          end else begin
            mon_e = exp_q.pop_front();
            $display("step dut%0d imm=%h shift=%0d keep=%0d last=%0d",
                     d, out_imm[d], out_shift[d], out_keep[d], out_last[d]);
            chk("step_dut", 64'(d), 64'(mon_e.d));
            chk("imm", 64'(out_imm[d]), 64'(mon_e.imm));
            chk("shift", 64'(out_shift[d]), 64'(mon_e.shift));
            chk("keep", 64'(out_keep[d]), 64'(mon_e.keep));
            chk("last", 64'(out_last[d]), 64'(mon_e.last));
            if (!out_keep[d])
              rep[d] = {48'd0, out_imm[d]} << {out_shift[d], 4'b0000};
            else
              rep[d][{out_shift[d], 4'b0000} +: 16] = out_imm[d];
            if (mon_e.last) chk("replay", rep[d], mon_e.value);
          end
        end
        stall_seen[d] = out_valid[d] && !out_ready[d];
        stall_out[d]  = {out_imm[d], out_shift[d], out_keep[d], out_last[d]};
      end
    end
  end

  // Present a constant; in_valid stays high afterwards to show it is ignored.
  task automatic send(input int d, input logic [63:0] v);
    int t = 0;
    while (!in_ready[d] && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ready_before_send", 64'(in_ready[d]), 64'd1);
    rep[d]      = 64'hA5A5_5A5A_F0F0_0F0F;
    in_valid[d] = 1'b1;
    in_value[d] = v;
    @(posedge clk); #1;
    in_value[d] = ~v;
    chk("capture_in_ready", 64'(in_ready[d]), 64'd0);
    chk("capture_out_valid", 64'(out_valid[d]), 64'd1);
  endtask

  // Drive out_ready from pat (then 1) until the block is idle again.
  task automatic run(input int d, input logic [15:0] pat, input int len,
                     input logic [2:0] exp_count, input int exp_cycles);
    int cycles = 0;
    bit done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      out_ready[d] = (c < len) ? pat[c] : 1'b1;
      @(posedge clk); #1;
      cycles = c + 1;
      if (in_ready[d]) done = 1'b1;
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b0;
    chk("seq_done", 64'(done), 64'd1);
    chk("seq_cycles", 64'(cycles), 64'(exp_cycles));
    chk("step_count", 64'(step_count[d]), 64'(exp_count));
    chk("idle_out_valid", 64'(out_valid[d]), 64'd0);
    chk("idle_out_imm", 64'(out_imm[d]), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    chk("step_count_hold", 64'(step_count[d]), 64'(exp_count));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_value[d] = 64'd0; out_ready[d] = 1'b0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_in_ready", 64'(in_ready[d]), 64'd1);
      chk("reset_out_valid", 64'(out_valid[d]), 64'd0);
      chk("reset_out_imm", 64'(out_imm[d]), 64'd0);
      chk("reset_flags", 64'({out_shift[d], out_keep[d], out_last[d]}), 64'd0);
      chk("reset_step_count", 64'(step_count[d]), 64'd0);
    end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Zero constant: single MOVZ #0.
    push(1, 16'h0000, 2'd0, 1'b0, 1'b1, 64'h0);
    send(1, 64'h0);
    run(1, 16'hFFFF, 0, 3'd1, 1);

    // Two non-zero halfwords, no bubble between steps.
    push(1, 16'hABCD, 2'd0, 1'b0, 1'b0, 64'h1234_0000_0000_ABCD);
    push(1, 16'h1234, 2'd3, 1'b1, 1'b1, 64'h1234_0000_0000_ABCD);
    send(1, 64'h1234_0000_0000_ABCD);
    run(1, 16'hFFFF, 0, 3'd2, 2);

    // Single non-zero halfword at index 2.
    push(1, 16'h5555, 2'd2, 1'b0, 1'b1, 64'h0000_5555_0000_0000);
    send(1, 64'h0000_5555_0000_0000);
    run(1, 16'hFFFF, 0, 3'd1, 1);

    // Full constant under backpressure: ready 0,0,1,0,1,1,1.
    push(1, 16'hCCCC, 2'd0, 1'b0, 1'b0, 64'hFFFF_EEEE_DDDD_CCCC);
    push(1, 16'hDDDD, 2'd1, 1'b1, 1'b0, 64'hFFFF_EEEE_DDDD_CCCC);
    push(1, 16'hEEEE, 2'd2, 1'b1, 1'b0, 64'hFFFF_EEEE_DDDD_CCCC);
    push(1, 16'hFFFF, 2'd3, 1'b1, 1'b1, 64'hFFFF_EEEE_DDDD_CCCC);
    send(1, 64'hFFFF_EEEE_DDDD_CCCC);
    run(1, 16'b111_0100, 7, 3'd4, 7);

    // SKIP_ZERO=0: all four steps even for zero halfwords.
    push(0, 16'h0000, 2'd0, 1'b0, 1'b0, 64'h0000_0000_0001_0000);
    push(0, 16'h0001, 2'd1, 1'b1, 1'b0, 64'h0000_0000_0001_0000);
    push(0, 16'h0000, 2'd2, 1'b1, 1'b0, 64'h0000_0000_0001_0000);
    push(0, 16'h0000, 2'd3, 1'b1, 1'b1, 64'h0000_0000_0001_0000);
    send(0, 64'h0000_0000_0001_0000);
    run(0, 16'hFFFF, 0, 3'd4, 4);

    // Reset after the first step aborts the sequence.
    push(1, 16'hABCD, 2'd0, 1'b0, 1'b0, 64'h1234_0000_0000_ABCD);
    send(1, 64'h1234_0000_0000_ABCD);
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b0;
    chk("pre_abort_shift", 64'(out_shift[1]), 64'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid[1]), 64'd0);
    chk("abort_in_ready", 64'(in_ready[1]), 64'd1);
    chk("abort_step_count", 64'(step_count[1]), 64'd0);
    chk("abort_queue", 64'(exp_q.size()), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    push(1, 16'h0007, 2'd0, 1'b0, 1'b1, 64'h7);
    send(1, 64'h7);
    run(1, 16'hFFFF, 0, 3'd1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mov_sequencer.md
Name: mov_sequencer

Overview:
- Decomposes a 64-bit constant into the ordered MOVZ/MOVK step sequence that rebuilds it 16 bits at a time.
- Each step carries a 16-bit immediate, a 2-bit halfword shift and a keep flag (MOVZ vs MOVK).
- Used by the constant-materialisation path ahead of the register-write datapath: the write side inserts halfwords, this block extracts them.
- Input and output are both valid/ready handshakes; one constant is in flight at a time.

Parameters:
SKIP_ZERO, 1, 1 = omit MOVK steps for all-zero halfwords; 0 = always emit all four steps.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  in_value is presented
in_ready  out  1  block can accept a constant (state IDLE)
in_value  in  64  constant to decompose
out_valid  out  1  a step is presented
out_ready  in  1  consumer accepts the step
out_imm  out  16  halfword immediate
out_shift  out  2  halfword index (0..3 = bits 15:0 .. 63:48)
out_keep  out  1  0 = MOVZ (clear other bits), 1 = MOVK (keep other bits)
out_last  out  1  current step is the final one of the sequence
step_count  out  3  steps accepted so far in the current/most recent sequence

Behaviour:
- Reset (reset_n low, async, any state): state IDLE; in_ready=1; out_valid=0; out_imm=0; out_shift=0; out_keep=0; out_last=0; step_count=0; captured value and mask cleared.
- States: IDLE, EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready at edge N: register in_value; set step_count=0; go to EMIT.
  - Mask: bit k = (halfword k != 0) if SKIP_ZERO=1, else 4'b1111. An all-zero mask is forced to 4'b0001.
- EMIT:
  - in_ready=0, out_valid=1 starting the cycle after edge N (latency 1).
  - Current index i = lowest set mask bit. out_imm = value[16i+15:16i]; out_shift = i.
  - out_keep = 0 for the first step of a sequence, 1 for every later step.
  - out_last = 1 when exactly one mask bit remains.
- Step acceptance (out_valid&&out_ready):
  - Clear mask bit i; step_count++.
  - If out_last: go to IDLE. in_ready=1 the next cycle, out_valid=0 and out_* return to 0.
  - Otherwise present the next step the very next cycle, with no bubble.
- Backpressure: while out_valid&&!out_ready, out_imm, out_shift, out_keep and out_last hold stable. A step is never dropped or repeated.
- in_valid during EMIT is ignored (not captured). in_value changes after capture do not affect the sequence.
- A new constant is accepted no earlier than the cycle after the last step's acceptance; minimum gap is 1 idle cycle.
- Steps are always ascending in shift order. Sequence length is 1..4.
- step_count holds its final value in IDLE until the next capture.
- Correctness property: starting from any register value, applying the steps in order (MOVZ: reg = imm<<16*shift; MOVK: replace halfword shift with imm) yields exactly the captured in_value.
- Reset asserted mid-sequence aborts immediately. No partial state survives; after release, behaviour is as from cold reset.

Test Plan:
- SKIP_ZERO=1, in_value=64'h0, out_ready=1 -> one step: imm=16'h0000, shift=0, keep=0, last=1. step_count=1; in_ready high the cycle after.
- SKIP_ZERO=1, in_value=64'h1234_0000_0000_ABCD -> step 1: imm=ABCD, shift=0, keep=0, last=0. Step 2 on the next cycle: imm=1234, shift=3, keep=1, last=1. step_count=2.
- SKIP_ZERO=1, in_value=64'h0000_5555_0000_0000 -> single step: imm=5555, shift=2, keep=0, last=1.
- in_value=64'hFFFF_EEEE_DDDD_CCCC, out_ready toggled 0,0,1,0,1,1,1 -> four steps CCCC/0, DDDD/1, EEEE/2, FFFF/3. Outputs stable while stalled. Only the first step has keep=0; no duplicate or missing step.
- SKIP_ZERO=0, in_value=64'h0000_0000_0001_0000 -> four steps: 0000/0 keep0; 0001/1 keep1; 0000/2 keep1; 0000/3 keep1 last=1. Replaying them into a register gives in_value.
- Mid-sequence reset_n pulse after step 1 of 64'h1234_0000_0000_ABCD -> out_valid drops asynchronously and in_ready=1. After release, in_value=64'h7 yields one step: imm=0007, shift=0, keep=0, last=1.
